// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUControl code constants and execute FSM state type
package alu_pkg;

  localparam logic [5:0] OP_SLL    = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_SRL    = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_JR     = 6'b001000;
  localparam logic [5:0] OP_MUL    = 6'b011000;
  localparam logic [5:0] OP_ADD    = 6'b100000;
  localparam logic [5:0] OP_SUB    = 6'b100010;
  localparam logic [5:0] OP_AND    = 6'b100100;
  localparam logic [5:0] OP_OR     = 6'b100101;
  localparam logic [5:0] OP_XOR    = 6'b100110;
  localparam logic [5:0] OP_NOR    = 6'b100111;
  localparam logic [5:0] OP_SLT    = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module mul_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic [31:0] acc_next;

  // product reflects the accumulator including this cycle's partial, so the
  // consumer can register the final value on the same edge the last step lands
  assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
  assign done     = busy && (cnt == 5'd31);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      cnt    <= 5'd0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= 32'd0;
      cnt    <= 5'd0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= {mcand[30:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU: single-cycle ops, branch compare, 33-cycle MUL
module alu_exec
  import alu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidIn,
  input  logic [5:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  input  logic        RtBit,
  output logic [31:0] Result,
  output logic        BranchTaken,
  output logic        ValidOut,
  output logic        Stall
);

  alu_state_t  state;
  logic        accept;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;
  logic [31:0] op_result;
  logic        op_branch;

  assign accept    = ValidIn && !Stall;
  assign mul_start = accept && (ALUControl == OP_MUL);

  // the multiplier's busy flag is registered and spans exactly the MUL state
  assign Stall = mul_busy;

  mul_iter u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    op_result = 32'd0;
    op_branch = 1'b0;
    case (ALUControl)
      OP_ADD:  op_result = A + B;
      OP_SUB:  op_result = A - B;
      OP_AND:  op_result = A & B;
      OP_OR:   op_result = A | B;
      OP_NOR:  op_result = ~(A | B);
      OP_XOR:  op_result = A ^ B;
      OP_SLL:  op_result = B << Shamt;
      OP_SRL:  op_result = B >> Shamt;
      OP_SLT:  op_result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      OP_JR, OP_JAL: op_result = A;
      OP_BEQ:  op_branch = (A == B);
      OP_BNE:  op_branch = (A != B);
      OP_BGTZ: op_branch = ($signed(A) > 32'sd0);
      OP_BLEZ: op_branch = ($signed(A) <= 32'sd0);
      OP_REGIMM: op_branch = RtBit ? !A[31] : A[31];
      default: begin
        op_result = 32'd0;
        op_branch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      Result      <= 32'd0;
      BranchTaken <= 1'b0;
      ValidOut    <= 1'b0;
    end else begin
      ValidOut <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (mul_start) begin
            state <= S_MUL;
          end else if (accept) begin
            Result      <= op_result;
            BranchTaken <= op_branch;
            ValidOut    <= 1'b1;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state       <= S_DONE;
            Result      <= mul_product;
            BranchTaken <= 1'b0;
            ValidOut    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec
module tb_alu_exec;

  logic        Clk;
  logic        Reset;
  logic        ValidIn;
  logic [5:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        RtBit;
  logic [31:0] Result;
  logic        BranchTaken;
  logic        ValidOut;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic        rt;
    logic [31:0] r;
    logic        bt;
  } vec_t;

  alu_exec dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ValidIn     (ValidIn),
    .ALUControl  (ALUControl),
    .A           (A),
    .B           (B),
    .Shamt       (Shamt),
    .RtBit       (RtBit),
    .Result      (Result),
    .BranchTaken (BranchTaken),
    .ValidOut    (ValidOut),
    .Stall       (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input logic rt);
    @(negedge Clk);
    ALUControl = c; A = a; B = b; Shamt = s; RtBit = rt; ValidIn = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge Clk);
    ValidIn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ValidIn = 1'b0; ALUControl = 6'd0; A = 0; B = 0; Shamt = 0; RtBit = 0;
    #1;
    checks++;
    if (Result !== 32'd0 || BranchTaken !== 1'b0 || ValidOut !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Result=%h BT=%b VO=%b Stall=%b, required all zero",
               Result, BranchTaken, ValidOut, Stall);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_ops();
    vec_t v[$];
    v.push_back('{6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 32'h80000000, 1'b0});
    v.push_back('{6'b100010, 32'd5, 32'd7, 5'd0, 1'b0, 32'hFFFFFFFE, 1'b0});
    v.push_back('{6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0, 32'hF000F000, 1'b0});
    v.push_back('{6'b100101, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 1'b0, 32'hFFFFF0F0, 1'b0});
    v.push_back('{6'b100111, 32'h0000FFFF, 32'h00FF0000, 5'd0, 1'b0, 32'hFF000000, 1'b0});
    v.push_back('{6'b100110, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 1'b0, 32'h55555555, 1'b0});
    v.push_back('{6'b000000, 32'h0, 32'h1, 5'd31, 1'b0, 32'h80000000, 1'b0});
    v.push_back('{6'b000010, 32'h0, 32'h80000000, 5'd31, 1'b0, 32'h1, 1'b0});
    v.push_back('{6'b101010, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h1, 1'b0});
    v.push_back('{6'b101010, 32'h1, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 1'b0});
    v.push_back('{6'b001000, 32'h12345678, 32'h0, 5'd0, 1'b0, 32'h12345678, 1'b0});
    v.push_back('{6'b000011, 32'h00400000, 32'h0, 5'd0, 1'b0, 32'h00400000, 1'b0});
    v.push_back('{6'b111111, 32'h5, 32'h6, 5'd3, 1'b0, 32'h0, 1'b0});
    v.push_back('{6'b000100, 32'd9, 32'd9, 5'd0, 1'b0, 32'h0, 1'b1});
    v.push_back('{6'b000101, 32'd9, 32'd9, 5'd0, 1'b0, 32'h0, 1'b0});
    v.push_back('{6'b000101, 32'd9, 32'd8, 5'd0, 1'b0, 32'h0, 1'b1});
    v.push_back('{6'b000001, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 1'b1});
    v.push_back('{6'b000001, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0});
    v.push_back('{6'b000001, 32'h80000000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1});
    v.push_back('{6'b000110, 32'h80000000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1});
    v.push_back('{6'b000111, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0});
    v.push_back('{6'b000111, 32'h5, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1});
    v.push_back('{6'b111111, 32'h5, 32'h6, 5'd0, 1'b1, 32'h0, 1'b0});
    // issued back to back: ValidOut must stay high on every cycle
    foreach (v[i]) begin
      drive(v[i].c, v[i].a, v[i].b, v[i].s, v[i].rt);
      checks++;
      if (ValidOut !== 1'b1 || Result !== v[i].r || BranchTaken !== v[i].bt) begin
        errors++;
        $display("FAIL op[%0d] code=%b: VO=%b Result=%h BT=%b, required VO=1 Result=%h BT=%b",
                 i, v[i].c, ValidOut, Result, BranchTaken, v[i].r, v[i].bt);
      end
    end
    go_idle();
  endtask

  task automatic test_hold();
    drive(6'b100000, 32'd20, 32'd22, 5'd0, 1'b0);
    go_idle();
    @(posedge Clk);
    #1;
    checks++;
    if (ValidOut !== 1'b0 || Result !== 32'd42 || BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: VO=%b Result=%h BT=%b, required VO=0 Result=0000002a BT=0",
               ValidOut, Result, BranchTaken);
    end
  endtask

  task automatic test_mul();
    int lat;
    int stall_cycles;
    drive(6'b011000, 32'hFFFFFFFF, 32'd3, 5'd0, 1'b0);
    @(negedge Clk);
    ALUControl = 6'b100000; A = 32'd1; B = 32'd1;
    lat = 1;
    stall_cycles = 0;
    while (ValidOut !== 1'b1 && lat < 40) begin
      if (Stall === 1'b1) stall_cycles++;
      @(posedge Clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 33 || stall_cycles !== 32) begin
      errors++;
      $display("FAIL mul_timing: latency=%0d stall_cycles=%0d, required latency=33 stall_cycles=32",
               lat, stall_cycles);
    end
    checks++;
    if (Result !== 32'hFFFFFFFD || Stall !== 1'b0 || BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: Result=%h Stall=%b BT=%b, required Result=fffffffd Stall=0 BT=0",
               Result, Stall, BranchTaken);
    end
    go_idle();
    @(posedge Clk);
    #1;
    checks++;
    if (ValidOut !== 1'b0 || Result !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL mul_add_dropped: VO=%b Result=%h, required VO=0 Result=fffffffd",
               ValidOut, Result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    drive(6'b011000, 32'd7, 32'd9, 5'd0, 1'b0);
    go_idle();
    repeat (9) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (Result !== 32'd0 || BranchTaken !== 1'b0 || ValidOut !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: Result=%h BT=%b VO=%b Stall=%b, required all zero",
               Result, BranchTaken, ValidOut, Stall);
    end
    @(negedge Clk);
    Reset = 1'b0;
    ALUControl = 6'b100000; A = 32'd2; B = 32'd2; Shamt = 0; RtBit = 0; ValidIn = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (ValidOut !== 1'b1 || Result !== 32'd4 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: VO=%b Result=%h Stall=%b, required VO=1 Result=00000004 Stall=0",
               ValidOut, Result, Stall);
    end
    go_idle();
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (ValidOut === 1'b1) spurious++;
    end
    checks++;
    if (spurious !== 0 || Result !== 32'd4) begin
      errors++;
      $display("FAIL aborted_mul_silent: ValidOut pulses=%0d Result=%h, required 0 pulses Result=00000004",
               spurious, Result);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_mul();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
